// File: rtl/gen_output_packer.sv
// gen_output_packer
//   Converts the signed fixed-point tanh stream from generator_v3 into 8-bit
//   unsigned pixels and tags each one with its raster position. Pixels are
//   queued in a first-word-fall-through FIFO and presented on a valid/ready
//   interface. The generator cannot be stalled, so a pixel arriving at a full
//   FIFO with no pop in the same cycle is dropped and the sticky overflow
//   flag is raised.
//
// Ports
//   clk, rst      : single clock, synchronous active-high reset
//   valid_in      : input sample strobe
//   data_in       : signed two's complement sample, FRAC_BITS fractional bits
//   m_valid       : head entry of the FIFO is valid
//   m_ready       : sink accepts the head entry
//   m_pixel       : unsigned pixel (0..255)
//   m_sof/eol/eof : start of frame, end of line, end of frame flags
//   frame_done    : one-cycle pulse when the last sample of a frame is taken
//   frame_count   : completed input frames, wraps at 2^16
//   overflow      : sticky, a pixel was dropped because the FIFO was full
module gen_output_packer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IMG_W      = 32,
    parameter int unsigned IMG_H      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_pixel,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  overflow
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned UW    = DATA_WIDTH + 1;
    localparam int unsigned PW    = DATA_WIDTH + 9;
    localparam int unsigned EW    = 11;

    localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic signed [UW-1:0] ONE      = UW'(1 << FRAC_BITS);
    localparam logic signed [UW-1:0] NEG_ONE  = -ONE;
    localparam logic [AW:0]          FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // ---------------- position counters ----------------
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             at_sof, at_eol, at_eof;

    assign at_sof = (col == '0) && (row == '0);
    assign at_eol = (col == COL_LAST);
    assign at_eof = at_eol && (row == ROW_LAST);

    // Counters run on every accepted sample, independent of FIFO drops,
    // so raster alignment survives an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (valid_in) begin
                if (at_eol) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row         <= '0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1: clamp and offset ----------------
    logic signed [UW-1:0] din_ext;
    logic signed [UW-1:0] clamped;
    logic        [UW-1:0] u_next;

    always_comb begin
        din_ext = {data_in[DATA_WIDTH-1], data_in};
        if (din_ext > ONE) begin
            clamped = ONE;
        end else if (din_ext < NEG_ONE) begin
            clamped = NEG_ONE;
        end else begin
            clamped = din_ext;
        end
        u_next = clamped + ONE;
    end

    logic          s1_valid;
    logic [UW-1:0] s1_u;
    logic          s1_sof, s1_eol, s1_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_u     <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_u   <= u_next;
                s1_sof <= at_sof;
                s1_eol <= at_eol;
                s1_eof <= at_eof;
            end
        end
    end

    // ---------------- stage 2: scale to 8 bits ----------------
    logic [PW-1:0] prod;
    logic [PW-1:0] scaled;
    logic [7:0]    pix;

    // u <= 2^(FRAC_BITS+1) bounds the result to 255; the saturation only
    // keeps every product bit observed.
    always_comb begin
        prod   = PW'(s1_u) * PW'(255);
        scaled = prod >> (FRAC_BITS + 1);
        pix    = (|scaled[PW-1:8]) ? 8'hFF : scaled[7:0];
    end

    logic          s2_valid;
    logic [EW-1:0] s2_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry <= {pix, s1_sof, s1_eol, s1_eof};
            end
        end
    end

    // ---------------- output FIFO (first-word-fall-through) ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [EW-1:0] hold;
    logic [EW-1:0] out_entry;
    logic          empty, full, pop, push, drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && m_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still
    // accept the stage-2 pixel when the sink drains one.
    assign push  = s2_valid && (!full || pop);
    assign drop  = s2_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // When empty, the data lines keep showing the last popped entry.
    assign out_entry = empty ? hold : mem[rd_ptr];
    assign m_valid   = !empty;
    assign m_pixel   = out_entry[10:3];
    assign m_sof     = out_entry[2];
    assign m_eol     = out_entry[1];
    assign m_eof     = out_entry[0];

endmodule

// File: doc/gen_output_packer.md
# gen_output_packer

Downstream stage of `generator_v3`: consumes its `valid_out`/`data_out` stream of signed fixed-point tanh outputs and converts each sample to an 8-bit unsigned pixel. It tags every pixel with raster position flags (start of frame, end of line, end of frame) and buffers the pixels in a FIFO. The FIFO presents them on a valid/ready interface to the frame sink (frame buffer / UART dump). The generator has no backpressure, so data lost to a full FIFO is reported through a sticky `overflow` flag.

## Interface
- `DATA_WIDTH`, 16: input sample width; signed, two's complement.
- `FRAC_BITS`, 8: fractional bits of the input; 1.0 = `1<<FRAC_BITS`.
- `IMG_W`, 32: pixels per line.
- `IMG_H`, 32: lines per frame.
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥4.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `valid_in`  in  1: input sample strobe, driven from generator `valid_out`.
- `data_in`  in  DATA_WIDTH: signed sample, driven from generator `data_out`.
- `m_valid`  out  1: an output pixel is available.
- `m_ready`  in  1: sink accepts the pixel.
- `m_pixel`  out  8: unsigned pixel.
- `m_sof`  out  1: pixel is at (row 0, col 0).
- `m_eol`  out  1: pixel is at col IMG_W-1.
- `m_eof`  out  1: pixel is at (IMG_H-1, IMG_W-1).
- `frame_done`  out  1: one-cycle pulse when the last input sample of a frame is accepted into stage 1.
- `frame_count`  out  16: number of completed input frames; wraps at 2^16.
- `overflow`  out  1: sticky; a pixel was dropped.

## Operation
- **Stage 1 (register):**
  - Clamp `data_in` to [-2^FRAC_BITS, +2^FRAC_BITS].
  - Add the offset 2^FRAC_BITS, giving u in [0, 2^(FRAC_BITS+1)]; width DATA_WIDTH+1, no wrap.
  - Capture the raster position flags from the column/row counters.
- **Stage 2 (register):** pixel = (u·255) >> (FRAC_BITS+1).
  - Truncating; product width DATA_WIDTH+9.
  - Result lies in 0..255 by construction.
- **Stage 2 FIFO write:** push {pixel, sof, eol, eof} into the FIFO.
- **Position counters:**
  - `col` advances on each `valid_in`.
  - At IMG_W-1, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0, `frame_done` pulses and `frame_count` increments.
  - Counters advance even if the pixel is later dropped, so frame alignment is never lost.
- **FIFO:** first-word-fall-through.
  - `m_*` outputs show the head entry whenever `m_valid`=1.
  - A pop occurs when `m_valid & m_ready`.
- **Full FIFO:**
  - If stage 2 holds a pixel and the FIFO is full with no pop in the same cycle, the pixel is discarded and `overflow` is set to 1.
  - `overflow` stays at 1 until `rst`.
  - Full FIFO with a simultaneous pop: the write is accepted and the occupancy is unchanged.
- **Empty FIFO:** `m_valid`=0; the `m_*` data lines hold their last value; `m_ready` is ignored.
- **Reset (`rst`=1, including mid-frame):**
  - Pipeline valids cleared, FIFO emptied, `col`/`row`/`frame_count` = 0, `overflow` = 0.
  - The next accepted sample is treated as (0,0).
- **Reset values of all outputs:**
  - `m_valid`=0, `m_pixel`=0, `m_sof`=`m_eol`=`m_eof`=0.
  - `frame_done`=0, `frame_count`=0, `overflow`=0.

## Timing
- Sample accepted at edge N (`valid_in`=1):
  - stage 1 valid at N+1;
  - FIFO write at N+2;
  - `m_valid`=1 and the pixel visible after edge N+3 if the FIFO was empty.
- Latency from input to `m_valid`: 3 cycles.
- Throughput: 1 pixel/cycle in and out; back-to-back `valid_in` is supported with no bubbles.
- `frame_done` is high for exactly the cycle after the edge at which the last pixel of the frame is accepted.
- `frame_count` updates on that same edge.
- `m_pixel`, `m_sof`, `m_eol` and `m_eof` are stable while `m_valid`=1 and `m_ready`=0.
- `overflow` rises the cycle after the dropped write.

## Test plan
- **Conversion:** with `m_ready`=1, inputs 0x8000, -256, -1, 0, 128, 256, 0x7FFF → `m_pixel` 0, 0, 127, 127, 191, 255, 255. First output appears 3 cycles after the first input.
- **Full frame:** 1024 back-to-back samples (IMG_W=IMG_H=32), `m_ready`=1.
  - Exactly 1024 outputs.
  - `m_sof` only on output 0.
  - `m_eol` on outputs 31, 63, …, 1023.
  - `m_eof` only on output 1023.
  - One `frame_done` pulse; `frame_count`=1.
- **Backpressure without loss:** `m_ready` toggles 1/0 every cycle while 8 samples stream in → all 8 pixels are delivered in order and `overflow`=0.
- **Overflow:** `m_ready`=0 while 20 samples stream in (FIFO_DEPTH=16).
  - `m_valid`=1 with 16 entries held.
  - `overflow`=1.
  - After releasing `m_ready`, exactly 16 pixels arrive: the first 16 inputs.
  - Sending a second frame afterwards still yields `m_sof` on that frame's first pixel.
- **Full FIFO with simultaneous pop:** FIFO full, `m_ready`=1 for one cycle while a stage-2 write arrives → write accepted, occupancy stays 16, `overflow` stays 0.
- **Mid-frame reset:** `rst` asserted for 1 cycle after 500 samples.
  - All outputs return to their reset values.
  - The next sample emerges with `m_sof`=1.
  - `frame_count`=0 until a full 1024-sample frame completes.
